// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand forwarding for a five-stage pipeline.
// Detects read-after-write conflicts between the ID-stage sources and the
// EXE/MEM destinations. It either stalls on every conflict (stall-only mode)
// or stalls only on load-use and forwards MEM/WB results into EXE.
// It keeps its own copy of the sources of the instruction now in EXE, and
// counts stall cycles and cycles in which any operand was forwarded.
module hazard_forward_unit #(
    parameter int REG_W  = 4,
    parameter bit FWD_EN = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] src1,
    input  logic [REG_W-1:0] src2,
    input  logic             two_src,
    input  logic [REG_W-1:0] exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             mem_wb_en,
    input  logic [REG_W-1:0] wb_dest,
    input  logic             wb_wb_en,
    input  logic             freeze,
    output logic             hazard,
    output logic [1:0]       sel_src1,
    output logic [1:0]       sel_src2,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] fwd_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Operand mux codes.
    localparam logic [1:0] SEL_RF  = 2'd0;
    localparam logic [1:0] SEL_MEM = 2'd1;
    localparam logic [1:0] SEL_WB  = 2'd2;

    // Sources of the instruction currently in EXE.
    logic [REG_W-1:0] e_src1_r;
    logic [REG_W-1:0] e_src2_r;
    logic             e_two_src_r;
    logic             e_valid_r;

    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] fwd_cnt_r;

    logic             hazard_s;
    logic [1:0]       sel_src1_s;
    logic [1:0]       sel_src2_s;
    logic             any_fwd_s;

    // Selects the forwarding source for one EXE operand. MEM is checked first
    // because it holds the younger of the two in-flight results.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_W-1:0] idx,
        input logic             used,
        input logic [REG_W-1:0] m_dest,
        input logic             m_wb_en,
        input logic [REG_W-1:0] w_dest,
        input logic             w_wb_en
    );
        logic [1:0] sel;
        sel = SEL_RF;
        if (!used) begin
            sel = SEL_RF;
        end else if (m_wb_en && (idx == m_dest)) begin
            sel = SEL_MEM;
        end else if (w_wb_en && (idx == w_dest)) begin
            sel = SEL_WB;
        end else begin
            sel = SEL_RF;
        end
        return sel;
    endfunction

    // Stall request. It is purely combinational from the ID/EXE/MEM inputs.
    always_comb begin
        hazard_s = 1'b0;
        if (FWD_EN) begin
            hazard_s = exe_wb_en & exe_mem_r_en &
                       ((src1 == exe_dest) | (two_src & (src2 == exe_dest)));
        end else begin
            hazard_s = (exe_wb_en & (src1 == exe_dest)) |
                       (mem_wb_en & (src1 == mem_dest)) |
                       (exe_wb_en & two_src & (src2 == exe_dest)) |
                       (mem_wb_en & two_src & (src2 == mem_dest));
        end
    end

    // Forwarding selects for the instruction held in the EXE copy.
    always_comb begin
        sel_src1_s = SEL_RF;
        sel_src2_s = SEL_RF;
        if (FWD_EN && e_valid_r) begin
            sel_src1_s = fwd_sel(e_src1_r, 1'b1, mem_dest, mem_wb_en,
                                 wb_dest, wb_wb_en);
            sel_src2_s = fwd_sel(e_src2_r, e_two_src_r, mem_dest, mem_wb_en,
                                 wb_dest, wb_wb_en);
        end else begin
            sel_src1_s = SEL_RF;
            sel_src2_s = SEL_RF;
        end
        any_fwd_s = (sel_src1_s != SEL_RF) | (sel_src2_s != SEL_RF);
    end

    // EXE copy: a bubble on a stall, a capture of the ID sources otherwise,
    // and a hold while the pipeline is frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_src1_r    <= {REG_W{1'b0}};
            e_src2_r    <= {REG_W{1'b0}};
            e_two_src_r <= 1'b0;
            e_valid_r   <= 1'b0;
        end else if (!freeze) begin
            if (hazard_s) begin
                e_valid_r <= 1'b0;
            end else begin
                e_src1_r    <= src1;
                e_src2_r    <= src2;
                e_two_src_r <= two_src;
                e_valid_r   <= 1'b1;
            end
        end
    end

    // Saturating stall and forward statistics. They do not advance while the
    // pipeline is frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            fwd_cnt_r   <= {CNT_W{1'b0}};
        end else if (!freeze) begin
            if (hazard_s && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end
            if (any_fwd_s && (fwd_cnt_r != CNT_MAX)) begin
                fwd_cnt_r <= fwd_cnt_r + CNT_ONE;
            end
        end
    end

    assign hazard    = hazard_s;
    assign sel_src1  = sel_src1_s;
    assign sel_src2  = sel_src2_s;
    assign stall_cnt = stall_cnt_r;
    assign fwd_cnt   = fwd_cnt_r;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit. Three instances share one stimulus stream:
// forwarding mode, stall-only mode, and forwarding mode with 3-bit counters.
// A reference model of the pipeline's view is checked every cycle, and
// directed steps pin hand-computed values.
module tb_hazard_forward_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] src1, src2, exe_dest, mem_dest, wb_dest;
    logic       two_src, exe_wb_en, exe_mem_r_en, mem_wb_en, wb_wb_en, freeze;

    logic        hz_f, hz_s, hz_c;
    logic [1:0]  s1_f, s2_f, s1_s, s2_s, s1_c, s2_c;
    logic [15:0] sc_f, fc_f, sc_s, fc_s;
    logic [2:0]  sc_c, fc_c;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    hazard_forward_unit #(.REG_W(4), .FWD_EN(1'b1), .CNT_W(16)) dut_f (
        .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .wb_dest(wb_dest),
        .wb_wb_en(wb_wb_en), .freeze(freeze), .hazard(hz_f),
        .sel_src1(s1_f), .sel_src2(s2_f), .stall_cnt(sc_f), .fwd_cnt(fc_f));

    hazard_forward_unit #(.REG_W(4), .FWD_EN(1'b0), .CNT_W(16)) dut_s (
        .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .wb_dest(wb_dest),
        .wb_wb_en(wb_wb_en), .freeze(freeze), .hazard(hz_s),
        .sel_src1(s1_s), .sel_src2(s2_s), .stall_cnt(sc_s), .fwd_cnt(fc_s));

    hazard_forward_unit #(.REG_W(4), .FWD_EN(1'b1), .CNT_W(3)) dut_c (
        .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .wb_dest(wb_dest),
        .wb_wb_en(wb_wb_en), .freeze(freeze), .hazard(hz_c),
        .sel_src1(s1_c), .sel_src2(s2_c), .stall_cnt(sc_c), .fwd_cnt(fc_c));

    // ---------------- reference model ----------------
    // Per instance: forwarding enabled? and counter ceiling.
    bit fw_of[3]  = '{1'b1, 1'b0, 1'b1};
    int max_of[3] = '{65535, 65535, 7};

    // What the model believes the instruction in EXE looks like.
    bit       m_live[3];
    bit [3:0] m_a[3];
    bit [3:0] m_b[3];
    bit       m_b_used[3];
    int       m_stall[3];
    int       m_fwd[3];

    function automatic bit exp_hazard(bit fw);
        bit r1_exe, r2_exe, r1_mem, r2_mem;
        r1_exe = exe_wb_en && (src1 == exe_dest);
        r2_exe = exe_wb_en && two_src && (src2 == exe_dest);
        r1_mem = mem_wb_en && (src1 == mem_dest);
        r2_mem = mem_wb_en && two_src && (src2 == mem_dest);
        if (fw) return exe_mem_r_en && (r1_exe || r2_exe);
        return r1_exe || r2_exe || r1_mem || r2_mem;
    endfunction

    function automatic int exp_sel(int i, bit second);
        bit [3:0] r;
        r = second ? m_b[i] : m_a[i];
        if (!fw_of[i] || !m_live[i]) return 0;
        if (second && !m_b_used[i]) return 0;
        if (mem_wb_en && r == mem_dest) return 1;
        if (wb_wb_en && r == wb_dest) return 2;
        return 0;
    endfunction

    // Advance the model on each edge (cleared immediately by reset).
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                m_live[i] <= 1'b0; m_a[i] <= 4'd0; m_b[i] <= 4'd0;
                m_b_used[i] <= 1'b0; m_stall[i] <= 0; m_fwd[i] <= 0;
            end
        end else if (!freeze) begin
            for (int i = 0; i < 3; i++) begin
                if (exp_hazard(fw_of[i])) begin
                    m_live[i] <= 1'b0;
                    m_stall[i] <= (m_stall[i] < max_of[i]) ? m_stall[i] + 1 : m_stall[i];
                end else begin
                    m_live[i] <= 1'b1; m_a[i] <= src1; m_b[i] <= src2;
                    m_b_used[i] <= two_src;
                end
                if (exp_sel(i, 1'b0) != 0 || exp_sel(i, 1'b1) != 0)
                    m_fwd[i] <= (m_fwd[i] < max_of[i]) ? m_fwd[i] + 1 : m_fwd[i];
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("f.hazard", int'(hz_f), int'(exp_hazard(1'b1)));
        chk("s.hazard", int'(hz_s), int'(exp_hazard(1'b0)));
        chk("c.hazard", int'(hz_c), int'(exp_hazard(1'b1)));
        chk("f.sel1", int'(s1_f), exp_sel(0, 1'b0));
        chk("f.sel2", int'(s2_f), exp_sel(0, 1'b1));
        chk("s.sel1", int'(s1_s), exp_sel(1, 1'b0));
        chk("s.sel2", int'(s2_s), exp_sel(1, 1'b1));
        chk("c.sel1", int'(s1_c), exp_sel(2, 1'b0));
        chk("c.sel2", int'(s2_c), exp_sel(2, 1'b1));
        chk("f.stall_cnt", int'(sc_f), m_stall[0]);
        chk("s.stall_cnt", int'(sc_s), m_stall[1]);
        chk("c.stall_cnt", int'(sc_c), m_stall[2]);
        chk("f.fwd_cnt", int'(fc_f), m_fwd[0]);
        chk("s.fwd_cnt", int'(fc_s), m_fwd[1]);
        chk("c.fwd_cnt", int'(fc_c), m_fwd[2]);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        src1 = 4'd0; src2 = 4'd0; two_src = 1'b0;
        exe_dest = 4'd0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
        mem_dest = 4'd0; mem_wb_en = 1'b0;
        wb_dest = 4'd0; wb_wb_en = 1'b0; freeze = 1'b0;
    endtask

    // Directed sequence with hand-computed expectations.
    initial begin
        idle_inputs();
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        chk("L.reset.stall", int'(sc_f), 0);
        chk("L.reset.fwd", int'(fc_f), 0);
        chk("L.reset.sel1", int'(s1_f), 0);
        chk("L.reset.sel2", int'(s2_f), 0);
        cyc();

        // Load to r3 in EXE, ID reads r3: load-use stall in both modes.
        exe_wb_en = 1'b1; exe_mem_r_en = 1'b1; exe_dest = 4'd3; src1 = 4'd3;
        #1;
        chk("L.loaduse.hazard_f", int'(hz_f), 1);
        chk("L.loaduse.hazard_s", int'(hz_s), 1);
        cyc();
        chk("L.loaduse.stall_f", int'(sc_f), 1);
        chk("L.loaduse.sel1_f", int'(s1_f), 0);

        // Capture r5/r5, then both MEM and WB write r5: MEM wins.
        idle_inputs();
        src1 = 4'd5; src2 = 4'd5; two_src = 1'b1;
        cyc();
        src1 = 4'd1; src2 = 4'd2; two_src = 1'b0;
        mem_dest = 4'd5; mem_wb_en = 1'b1; wb_dest = 4'd5; wb_wb_en = 1'b1;
        #1;
        chk("L.prio.sel1_f", int'(s1_f), 1);
        chk("L.prio.sel2_f", int'(s2_f), 1);
        chk("L.prio.fwd_before", int'(fc_f), 0);
        chk("L.prio.sel1_s", int'(s1_s), 0);
        cyc();
        chk("L.prio.fwd_after", int'(fc_f), 1);

        // EXE copy has two_src=0 and src2=r2; WB writes r2: no forward.
        mem_wb_en = 1'b0; wb_dest = 4'd2; wb_wb_en = 1'b1;
        #1;
        chk("L.twosrc0.sel2_f", int'(s2_f), 0);
        cyc();

        // Stall-only mode: MEM writes r7, ID reads r7 as src2.
        mem_wb_en = 1'b1; mem_dest = 4'd7; src1 = 4'd0; src2 = 4'd7; two_src = 1'b1;
        wb_wb_en = 1'b0;
        #1;
        chk("L.stallonly.hazard_s", int'(hz_s), 1);
        chk("L.stallonly.hazard_f", int'(hz_f), 0);
        cyc();
        chk("L.stallonly.sel1_s", int'(s1_s), 0);
        chk("L.stallonly.sel2_s", int'(s2_s), 0);

        // Load-use stall, then freeze for three cycles, then resume.
        idle_inputs();
        exe_wb_en = 1'b1; exe_mem_r_en = 1'b1; exe_dest = 4'd9; src1 = 4'd9;
        cyc();
        chk("L.prefreeze.stall_f", int'(sc_f), 2);
        freeze = 1'b1;
        cyc(); cyc(); cyc();
        chk("L.freeze.stall_f", int'(sc_f), 2);
        chk("L.freeze.hazard_f", int'(hz_f), 1);
        freeze = 1'b0;
        cyc();
        chk("L.resume.stall_f", int'(sc_f), 3);

        // Ten more stall cycles: 3-bit counter saturates at 7.
        for (int k = 0; k < 10; k++) cyc();
        chk("L.sat.stall_c", int'(sc_c), 7);
        chk("L.sat.stall_f", int'(sc_f), 13);

        // Set up a live forward, then reset between edges.
        idle_inputs();
        src1 = 4'd4; mem_dest = 4'd4; mem_wb_en = 1'b1;
        cyc();
        chk("L.prereset.sel1_f", int'(s1_f), 1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("L.asyncrst.stall_f", int'(sc_f), 0);
        chk("L.asyncrst.stall_c", int'(sc_c), 0);
        chk("L.asyncrst.fwd_f", int'(fc_f), 0);
        chk("L.asyncrst.sel1_f", int'(s1_f), 0);
        chk("L.asyncrst.sel2_f", int'(s2_f), 0);
        idle_inputs();
        #1;
        rst = 1'b0;
        cyc();
        chk("L.postrst.stall_f", int'(sc_f), 0);
        chk("L.postrst.fwd_f", int'(fc_f), 0);
        cyc(); cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/hazard_forward_unit.md
HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 The block SHALL have parameter REG_W, default 4: register-index width.
REQ-002 The block SHALL have parameter FWD_EN, default 1: 1 = forwarding mode, 0 = stall-only mode.
REQ-003 The block SHALL have parameter CNT_W, default 16: statistics counter width.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous and active-high.
REQ-006 Port src1, src2, input, REG_W each: ID-stage source indices.
REQ-007 Port two_src, input, 1: ID instruction reads src2.
REQ-008 Port exe_dest, input, REG_W; port exe_wb_en, input, 1; port exe_mem_r_en, input, 1: EXE-stage destination, write enable and load flag.
REQ-009 Port mem_dest, input, REG_W; port mem_wb_en, input, 1: MEM-stage destination and write enable.
REQ-010 Port wb_dest, input, REG_W; port wb_wb_en, input, 1: WB-stage destination and write enable.
REQ-011 Port freeze, input, 1: pipeline-wide freeze (memory wait); internal state holds.
REQ-012 Port hazard, output, 1: stall IF/ID and insert bubble into ID/EXE.
REQ-013 Port sel_src1, sel_src2, output, 2 each: EXE operand mux select; 0 = register file, 1 = MEM result, 2 = WB result, 3 never driven.
REQ-014 Port stall_cnt, output, CNT_W: count of stall cycles.
REQ-015 Port fwd_cnt, output, CNT_W: count of cycles with any forward.

Function
REQ-016 With FWD_EN=0, hazard SHALL be combinational: (exe_wb_en & src1==exe_dest) | (mem_wb_en & src1==mem_dest) | (exe_wb_en & two_src & src2==exe_dest) | (mem_wb_en & two_src & src2==mem_dest).
REQ-017 With FWD_EN=1, hazard SHALL be combinational, load-use only: exe_wb_en & exe_mem_r_en & (src1==exe_dest | (two_src & src2==exe_dest)).
REQ-018 hazard SHALL NOT depend on freeze or internal state.
REQ-019 The block SHALL hold an internal EXE copy: e_src1, e_src2, e_two_src, e_valid.
REQ-020 On a clk edge with freeze=0 and hazard=1, the EXE copy SHALL load a bubble: e_valid=0.
REQ-021 On a clk edge with freeze=0 and hazard=0, the EXE copy SHALL capture src1, src2 and two_src, with e_valid=1.
REQ-022 On a clk edge with freeze=1, the EXE copy SHALL hold.
REQ-023 sel_src1 SHALL be combinational from the EXE copy: 0 if FWD_EN=0 or e_valid=0; else 1 if mem_wb_en & e_src1==mem_dest; else 2 if wb_wb_en & e_src1==wb_dest; else 0.
REQ-024 When both MEM and WB match, MEM SHALL take priority (youngest value).
REQ-025 sel_src2 SHALL follow the same rule using e_src2, additionally forced to 0 when e_two_src=0.
REQ-026 stall_cnt SHALL increment by 1 on each clk edge with hazard=1 and freeze=0.
REQ-027 stall_cnt SHALL saturate at 2^CNT_W-1, with no wrap.
REQ-028 fwd_cnt SHALL increment by 1 on each clk edge with freeze=0 and (sel_src1!=0 | sel_src2!=0).
REQ-029 fwd_cnt SHALL saturate at 2^CNT_W-1; with FWD_EN=0 it stays 0.
REQ-030 The stall_cnt and fwd_cnt outputs SHALL be registered.
REQ-031 Latency: hazard and sel SHALL be 0-cycle combinational; each counter SHALL reflect an event 1 cycle after the qualifying edge.
REQ-032 Index 0 SHALL be treated as an ordinary register, with no special-casing.
REQ-033 Simultaneous hazard=1 and freeze=1 SHALL hold state and leave the counters unchanged; hazard stays asserted.

Reset
REQ-034 While rst=1, the block SHALL asynchronously clear e_valid, e_src1, e_src2, e_two_src, stall_cnt and fwd_cnt to 0.
REQ-035 Immediately after reset, sel_src1 and sel_src2 SHALL be 0; hazard SHALL remain purely combinational from the inputs.
REQ-036 Reset asserted mid-stall SHALL discard the EXE copy and counters; the first edge after release SHALL behave as from the idle state.

Verification
REQ-037 FWD_EN=1: EXE load to r3 (exe_wb_en=1, exe_mem_r_en=1, exe_dest=3), src1=3 -> hazard=1; next edge e_valid=0, sel_src1=0, stall_cnt=1.
REQ-038 FWD_EN=1: capture src1=5, src2=5, two_src=1; then mem_dest=5 with mem_wb_en=1 and wb_dest=5 with wb_wb_en=1 -> sel_src1=1, sel_src2=1 (MEM priority); fwd_cnt increments.
REQ-039 FWD_EN=1: EXE-copy two_src=0 with src2 matching wb_dest -> sel_src2=0.
REQ-040 FWD_EN=0: mem_wb_en=1, mem_dest=7, src2=7, two_src=1 -> hazard=1; sel_src1 and sel_src2 are 0 in every cycle.
REQ-041 freeze=1 for 3 cycles during hazard=1 -> stall_cnt and the EXE copy unchanged; the count resumes after freeze drops.
REQ-042 CNT_W=3 with continuous hazard for 10 cycles -> stall_cnt reaches 7 and holds.
REQ-043 rst pulse between edges mid-sequence -> all counters and sel outputs go to 0 immediately, without waiting for clk.
